// File: rtl/sms4_lin_rot_unit.sv
// sms4_lin_rot_unit: iterative SMS4 linear transform engine.
// Computes L (round), L' (key schedule), a single programmable rotate-left,
// or a pass-through on one BWIDTH-bit word, applying one rotated term per clock.
// Bit 0 is the MSB on every data bus.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready depends only on state (high in IDLE); out_valid depends only on
// state (high in DONE) and never on out_ready. out_data is held stable while
// out_valid is high and not yet accepted.
module sms4_lin_rot_unit #(
    parameter int BWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_mode,
    input  logic [AWIDTH-1:0]   in_amt,
    input  logic [0:BWIDTH-1]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [0:BWIDTH-1]   out_data
);

    localparam logic [1:0] MODE_L    = 2'b00;
    localparam logic [1:0] MODE_LK   = 2'b01;
    localparam logic [1:0] MODE_ROT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [0:BWIDTH-1]   b_reg;
    logic [0:BWIDTH-1]   acc;
    logic [1:0]          mode_reg;
    logic [AWIDTH-1:0]   amt_reg;
    logic [1:0]          idx;
    logic [AWIDTH-1:0]   term_amt;
    logic                last_term;

    // Rotate-left with bit 0 as MSB: r[i] = b[(i+k) mod BWIDTH]. The index wraps
    // naturally because 2**AWIDTH == BWIDTH.
    function automatic logic [0:BWIDTH-1] rotl(input logic [0:BWIDTH-1] b,
                                              input logic [AWIDTH-1:0] k);
        logic [0:BWIDTH-1] r;
        logic [AWIDTH-1:0] j;
        r = '0;
        for (int i = 0; i < BWIDTH; i++) begin
            j = AWIDTH'(i) + k;
            r[i] = b[j];
        end
        return r;
    endfunction

    // Rotation amount of the term selected by idx for the latched mode.
    always_comb begin
        term_amt = '0;
        case (mode_reg)
            MODE_L: begin
                case (idx)
                    2'd0:    term_amt = AWIDTH'(2 % BWIDTH);
                    2'd1:    term_amt = AWIDTH'(10 % BWIDTH);
                    2'd2:    term_amt = AWIDTH'(18 % BWIDTH);
                    default: term_amt = AWIDTH'(24 % BWIDTH);
                endcase
            end
            MODE_LK:  term_amt = idx[0] ? AWIDTH'(23 % BWIDTH) : AWIDTH'(13 % BWIDTH);
            MODE_ROT: term_amt = amt_reg;
            default:  term_amt = '0;
        endcase
    end

    // True while the term being applied this cycle is the final one of its mode.
    always_comb begin
        last_term = 1'b0;
        if (mode_reg == MODE_L && idx == 2'd3) last_term = 1'b1;
        if (mode_reg == MODE_LK && idx == 2'd1) last_term = 1'b1;
    end

    // State register; reset wins over any handshake at the same edge.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = in_mode[1] ? DONE : CALC;
            CALC: if (last_term) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state only.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: latch operands on accept, then fold one rotated term per CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_reg    <= '0;
            acc      <= '0;
            mode_reg <= '0;
            amt_reg  <= '0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        b_reg    <= in_data;
                        mode_reg <= in_mode;
                        amt_reg  <= in_amt;
                        idx      <= '0;
                        acc      <= (in_mode == MODE_ROT) ? rotl(in_data, in_amt) : in_data;
                    end
                end
                CALC: begin
                    acc <= acc ^ rotl(b_reg, term_amt);
                    idx <= idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign out_data = acc;

endmodule

// File: tb/tb_sms4_lin_rot_unit.sv
// Self-checking bench for sms4_lin_rot_unit: directed cases, backpressure,
// mid-computation reset, and random traffic against a behavioural model.
module tb_sms4_lin_rot_unit;
  localparam int BW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [AW-1:0] in_amt;
  logic [0:BW-1] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [0:BW-1] out_data;

  int errors = 0;
  int checks = 0;
  logic [BW-1:0] exp_q[$];

  sms4_lin_rot_unit #(.BWIDTH(BW), .AWIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_amt    (in_amt),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: plain numeric rotates (MSB is bit 0 of the DUT bus)
  function automatic logic [31:0] ref_rotl(input logic [31:0] x, input int k);
    int kk;
    kk = k % 32;
    if (kk == 0) return x;
    return (x << kk) | (x >> (32 - kk));
  endfunction

  function automatic logic [31:0] ref_model(input logic [1:0] mode, input int amt,
                                            input logic [31:0] x);
    case (mode)
      2'b00:   return x ^ ref_rotl(x, 2) ^ ref_rotl(x, 10) ^ ref_rotl(x, 18) ^ ref_rotl(x, 24);
      2'b01:   return x ^ ref_rotl(x, 13) ^ ref_rotl(x, 23);
      2'b10:   return ref_rotl(x, amt);
      default: return x;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] mode);
    case (mode)
      2'b00:   return 4;
      2'b01:   return 2;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // driver: offer one word, wait for accept, then count cycles until out_valid
  task automatic send(input logic [1:0] mode, input logic [AW-1:0] amt,
                      input logic [31:0] data, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = mode;
    in_amt   = amt;
    in_data  = data;
    for (int t = 0; t < 20 && !in_ready; t++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 99;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
      check("busy_in_ready", {31'b0, in_ready}, 32'd0);
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("hs_out_valid", {31'b0, out_valid}, 32'd0);
    check("hs_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic txn(input string tag, input logic [1:0] mode, input logic [AW-1:0] amt,
                     input logic [31:0] data);
    int lat;
    send(mode, amt, data, lat);
    check({tag, "_lat"}, lat, ref_latency(mode));
    check({tag, "_data"}, out_data, ref_model(mode, int'(amt), data));
    handshake();
  endtask

  initial begin
    int lat;
    int got;
    int cyc;
    rst = 1'b1; in_valid = 1'b0; in_mode = '0; in_amt = '0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);

    // directed values
    send(2'b00, '0, 32'h0000_0001, lat);
    check("l_one_lat", lat, 4);
    check("l_one_data", out_data, 32'h0104_0405);
    handshake();
    send(2'b00, '0, 32'h8000_0000, lat);
    check("l_msb_data", out_data, 32'h8082_0202);
    handshake();
    send(2'b01, '0, 32'h0000_0001, lat);
    check("lk_one_lat", lat, 2);
    check("lk_one_data", out_data, 32'h0080_2001);
    handshake();
    send(2'b10, 5'd2, 32'h8000_0000, lat);
    check("rot2_lat", lat, 0);
    check("rot2_data", out_data, 32'h0000_0002);
    handshake();
    send(2'b10, 5'd0, 32'h1234_5678, lat);
    check("rot0_data", out_data, 32'h1234_5678);
    handshake();
    send(2'b10, 5'd31, 32'h0000_0001, lat);
    check("rot31_data", out_data, 32'h8000_0000);
    handshake();

    // backpressure with a competing word held on the input
    send(2'b11, '0, 32'hDEAD_BEEF, lat);
    check("pass_lat", lat, 0);
    in_valid = 1'b1; in_mode = 2'b11; in_data = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_data", out_data, 32'hDEAD_BEEF);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_bubble_valid", {31'b0, out_valid}, 32'd0);
    check("bp_bubble_ready", {31'b0, in_ready}, 32'd1);
    check("bp_bubble_data", out_data, 32'hDEAD_BEEF);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_valid", {31'b0, out_valid}, 32'd1);
    check("bp_second_data", out_data, 32'h1111_1111);
    handshake();

    // reset at the second CALC edge of an L computation
    @(negedge clk);
    in_valid = 1'b1; in_mode = 2'b00; in_data = 32'h0F0F_1234;
    @(posedge clk);
    #1 in_data = 32'h5555_AAAA;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("mrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mrst_out_data", out_data, 32'd0);
    got = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) got++;
    end
    check("mrst_no_result", got, 0);
    txn("post_rst", 2'b00, '0, 32'hA5A5_0F0F);

    // random single transactions
    for (int i = 0; i < 12; i++) begin
      txn($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), AW'($urandom_range(0, 31)), $urandom);
    end

    // back-to-back stream with random backpressure
    got = 0;
    fork
      begin
        for (int w = 0; w < 8; w++) begin
          logic [1:0]    m;
          logic [AW-1:0] a;
          logic [31:0]   d;
          logic          acc_now;
          m = 2'($urandom_range(0, 3));
          a = AW'($urandom_range(0, 31));
          d = $urandom;
          @(negedge clk);
          in_valid = 1'b1; in_mode = m; in_amt = a; in_data = d;
          exp_q.push_back(ref_model(m, int'(a), d));
          for (int t = 0; t < 60; t++) begin
            acc_now = in_ready;
            @(posedge clk);
            if (acc_now) break;
            @(negedge clk);
          end
          #1 in_valid = 1'b0;
        end
      end
      begin
        logic          v;
        logic          r;
        logic [31:0]   d;
        logic [31:0]   e;
        cyc = 0;
        while (got < 8 && cyc < 2000) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
          v = out_valid; r = out_ready; d = out_data;
          @(posedge clk);
          cyc++;
          if (v && r) begin
            if (exp_q.size() == 0) begin
              check("stream_unexpected", d, 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              check($sformatf("stream%0d", got), d, e);
            end
            got++;
          end
        end
        #1 out_ready = 1'b0;
      end
    join
    check("stream_count", got, 8);
    check("stream_queue_empty", exp_q.size(), 0);
    got = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) got++;
    end
    check("stream_no_extra", got, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
